// File: rtl/uart_csr_bank.sv
// uart_csr_bank: control/status register bank for the software-defined UART.
// Holds UCSRA/UCSRB/UBRR/UDR, a single-entry TX hold, a single-entry RX buffer
// and a registered, maskable interrupt request.
// Optional: define UART_CSR_SCRATCH_EN to add a read/write scratch register at address 4.
module uart_csr_bank #(
  parameter int          DATA_WIDTH = 32,
  parameter int          BAUD_WIDTH = 16,
  parameter int unsigned BAUD_RESET = 27
) (
  input  logic                  clock_50MHz,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  rx_frame_err,
  input  logic                  tx_ready,
  input  logic                  tx_done,
  output logic [7:0]            tx_data,
  output logic                  tx_load,
  output logic [BAUD_WIDTH-1:0] baud_div,
  output logic                  rx_enable,
  output logic                  tx_enable,
  output logic                  irq
);

  // UCSRA flags
  logic rxc_q, rxc_d, txc_q, txc_d, udre_q, udre_d;
  logic fe_q, fe_d, dor_q, dor_d, wov_q, wov_d;
  // UCSRB: {ERRIE, UDRIE, TXCIE, RXCIE, TXEN, RXEN}
  logic [5:0]            ucsrb_q, ucsrb_d;
  logic [BAUD_WIDTH-1:0] ubrr_q, ubrr_d;
  logic [7:0]            tx_hold_q, tx_hold_d, rx_buf_q, rx_buf_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_load_q, tx_load_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d, read_mux;
  logic                  read_valid_q, read_valid_d;
  logic                  irq_q, irq_d;
`ifdef UART_CSR_SCRATCH_EN
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
`endif

  logic load_fire, rx_go, rd_udr;
  logic unused_wdata;

  // Not every writeData bit lands in a register; fold them so none is left dangling.
  assign unused_wdata = ^writeData;

  // Next-state for all registers: software writes, then hardware events (sets win over W1C).
  always_comb begin
    rxc_d        = rxc_q;
    txc_d        = txc_q;
    udre_d       = udre_q;
    fe_d         = fe_q;
    dor_d        = dor_q;
    wov_d        = wov_q;
    ucsrb_d      = ucsrb_q;
    ubrr_d       = ubrr_q;
    tx_hold_d    = tx_hold_q;
    rx_buf_d     = rx_buf_q;
    tx_data_d    = tx_data_q;
    tx_load_d    = 1'b0;
    read_data_d  = read_data_q;
    read_valid_d = read;
    read_mux     = '0;
`ifdef UART_CSR_SCRATCH_EN
    scratch_d    = scratch_q;
`endif

    load_fire = !udre_q && ucsrb_q[1] && tx_ready;
    rd_udr    = read && (address == 3'd3);
    rx_go     = rx_done && ucsrb_q[0];

    // software writes; UDRE is read-only
    if (write) begin
      case (address)
        3'd0: begin
          if (writeData[0]) rxc_d = 1'b0;
          if (writeData[1]) txc_d = 1'b0;
          if (writeData[3]) fe_d  = 1'b0;
          if (writeData[4]) dor_d = 1'b0;
          if (writeData[5]) wov_d = 1'b0;
        end
        3'd1: ucsrb_d = writeData[5:0];
        3'd2: ubrr_d  = writeData[BAUD_WIDTH-1:0];
`ifdef UART_CSR_SCRATCH_EN
        3'd4: scratch_d = writeData;
`endif
        default: ;
      endcase
    end

    // TX hold hands its byte to the engine; the hold is free again at that same edge
    if (load_fire) begin
      tx_load_d = 1'b1;
      tx_data_d = tx_hold_q;
      udre_d    = 1'b1;
    end

    // UDR write fills an empty (or just-emptied) hold, otherwise flags the overrun
    if (write && (address == 3'd3)) begin
      if (udre_q || load_fire) begin
        tx_hold_d = writeData[7:0];
        udre_d    = 1'b0;
      end else begin
        wov_d = 1'b1;
      end
    end

    if (tx_done) txc_d = 1'b1;

    // reading UDR consumes the RX byte; a coincident arrival refills the buffer
    if (rd_udr) rxc_d = 1'b0;
    if (rx_go) begin
      if (!rxc_q || rd_udr) begin
        rx_buf_d = rx_data;
        rxc_d    = 1'b1;
        fe_d     = rx_frame_err;
      end else begin
        dor_d = 1'b1;
      end
    end

    // read mux sees pre-update state so a same-cycle write is not visible yet
    case (address)
      3'd0: read_mux[5:0] = {wov_q, dor_q, fe_q, udre_q, txc_q, rxc_q};
      3'd1: read_mux[5:0] = ucsrb_q;
      3'd2: read_mux[BAUD_WIDTH-1:0] = ubrr_q;
      3'd3: read_mux[7:0] = rx_buf_q;
`ifdef UART_CSR_SCRATCH_EN
      3'd4: read_mux = scratch_q;
`endif
      default: read_mux = '0;
    endcase
    if (read) read_data_d = read_mux;

    irq_d = (rxc_q & ucsrb_q[2]) | (txc_q & ucsrb_q[3]) | (udre_q & ucsrb_q[4]) |
            ((fe_q | dor_q | wov_q) & ucsrb_q[5]);
  end

  // State registers with synchronous reset that overrides every strobe.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      rxc_q        <= 1'b0;
      txc_q        <= 1'b0;
      udre_q       <= 1'b1;
      fe_q         <= 1'b0;
      dor_q        <= 1'b0;
      wov_q        <= 1'b0;
      ucsrb_q      <= '0;
      ubrr_q       <= BAUD_WIDTH'(BAUD_RESET);
      tx_hold_q    <= '0;
      rx_buf_q     <= '0;
      tx_data_q    <= '0;
      tx_load_q    <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      irq_q        <= 1'b0;
`ifdef UART_CSR_SCRATCH_EN
      scratch_q    <= '0;
`endif
    end else begin
      rxc_q        <= rxc_d;
      txc_q        <= txc_d;
      udre_q       <= udre_d;
      fe_q         <= fe_d;
      dor_q        <= dor_d;
      wov_q        <= wov_d;
      ucsrb_q      <= ucsrb_d;
      ubrr_q       <= ubrr_d;
      tx_hold_q    <= tx_hold_d;
      rx_buf_q     <= rx_buf_d;
      tx_data_q    <= tx_data_d;
      tx_load_q    <= tx_load_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      irq_q        <= irq_d;
`ifdef UART_CSR_SCRATCH_EN
      scratch_q    <= scratch_d;
`endif
    end
  end

  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign baud_div  = ubrr_q;
  assign rx_enable = ucsrb_q[0];
  assign tx_enable = ucsrb_q[1];
  assign irq       = irq_q;

endmodule
